// File: rtl/ps2_packet_rx_if.sv
// PS/2 receiver bus: raw PS/2 lines in, decoded byte/packet/status out.
// Latency: none, wiring only.
// Backpressure: none; outputs are pulses or held values with no ready.
interface ps2_packet_rx_if #(
  parameter int PACKET_BYTES = 3
) ();
  logic                      clk_ps2;
  logic                      data_ps2;
  logic [7:0]                byte_data;
  logic                      byte_valid;
  logic [8*PACKET_BYTES-1:0] packet_data;
  logic                      packet_valid;
  logic                      parity_error;
  logic                      frame_error;
  logic                      align_error;
  logic                      busy;

  // receiver side: consumes the PS/2 lines, produces decoded results
  modport master (
    input  clk_ps2, data_ps2,
    output byte_data, byte_valid, packet_data, packet_valid,
           parity_error, frame_error, align_error, busy
  );

  // device/consumer side: drives the PS/2 lines, observes results
  modport slave (
    output clk_ps2, data_ps2,
    input  byte_data, byte_valid, packet_data, packet_valid,
           parity_error, frame_error, align_error, busy
  );
endinterface

// File: rtl/ps2_packet_rx.sv
// PS/2 frame receiver with line sync, clock glitch filter and multi-byte packet assembly.
// Latency: byte/packet pulses one clk after the stop-bit strobe (strobe trails the raw fall by sync+filter).
// Backpressure: none; results are single-cycle pulses, consumer must take them when asserted.
module ps2_packet_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int PACKET_BYTES   = 3,
  parameter bit SYNC_BIT_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  ps2_packet_rx_if.master bus
);

  localparam int FLT_W = $clog2(FILTER_LEN) + 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int IDX_W = (PACKET_BYTES > 1) ? $clog2(PACKET_BYTES) : 1;
  localparam int PKT_W = 8 * PACKET_BYTES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_s;
  logic                   dat_s;
  logic [FLT_W-1:0]       flt_cnt;
  logic                   clk_filt;
  logic                   strobe;

  state_t                 state;
  logic [2:0]             bitcnt;
  logic [7:0]             shreg;
  logic                   par_bit;
  logic [TO_W-1:0]        to_cnt;
  logic [IDX_W-1:0]       idx;
  logic [PKT_W-1:0]       slot_q;
  logic [PKT_W-1:0]       next_pkt;
  logic                   par_ok;

  logic [7:0]             byte_data_q;
  logic                   byte_valid_q;
  logic [PKT_W-1:0]       packet_data_q;
  logic                   packet_valid_q;
  logic                   parity_error_q;
  logic                   frame_error_q;
  logic                   align_error_q;

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  // Same-depth synchronisers on both lines so data stays aligned to the clock
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], bus.clk_ps2};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], bus.data_ps2};
    end
  end

  // Filtered clock follows the synced clock only after FILTER_LEN agreeing samples;
  // a falling transition of the filtered clock produces a one-cycle strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flt_cnt  <= '0;
      clk_filt <= 1'b1;
      strobe   <= 1'b0;
    end else if (clk_s != clk_filt) begin
      if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s;
        flt_cnt  <= '0;
        strobe   <= clk_filt & ~clk_s;
      end else begin
        flt_cnt  <= flt_cnt + 1'b1;
        strobe   <= 1'b0;
      end
    end else begin
      flt_cnt <= '0;
      strobe  <= 1'b0;
    end
  end

  // Odd parity over data plus parity bit; packet image with the current byte dropped into its slot
  always_comb begin
    par_ok                 = ^{shreg, par_bit};
    next_pkt               = slot_q;
    next_pkt[8*idx +: 8]   = shreg;
  end

  // Frame FSM, timeout, byte/packet assembly and all registered result pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      bitcnt         <= '0;
      shreg          <= '0;
      par_bit        <= 1'b0;
      to_cnt         <= '0;
      idx            <= '0;
      slot_q         <= '0;
      byte_data_q    <= '0;
      byte_valid_q   <= 1'b0;
      packet_data_q  <= '0;
      packet_valid_q <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      align_error_q  <= 1'b0;
    end else begin
      byte_valid_q   <= 1'b0;
      packet_valid_q <= 1'b0;
      parity_error_q <= 1'b0;
      frame_error_q  <= 1'b0;
      align_error_q  <= 1'b0;

      if (strobe || state == IDLE) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (strobe) begin
        case (state)
          IDLE: begin
            // a high data line here is a stray edge, not a start bit
            if (!dat_s) begin
              state  <= DATA;
              bitcnt <= '0;
            end
          end
          DATA: begin
            shreg[bitcnt] <= dat_s;
            bitcnt        <= bitcnt + 1'b1;
            if (bitcnt == 3'd7) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_bit <= dat_s;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s && par_ok) begin
              byte_data_q  <= shreg;
              byte_valid_q <= 1'b1;
              if (SYNC_BIT_CHECK && idx == '0 && !shreg[3]) begin
                // misaligned stream: report it and keep waiting for a valid first byte
                align_error_q <= 1'b1;
              end else begin
                slot_q[8*idx +: 8] <= shreg;
                if (idx == IDX_W'(PACKET_BYTES - 1)) begin
                  packet_data_q  <= next_pkt;
                  packet_valid_q <= 1'b1;
                  idx            <= '0;
                end else begin
                  idx <= idx + 1'b1;
                end
              end
            end else begin
              parity_error_q <= ~par_ok;
              frame_error_q  <= ~dat_s;
              idx            <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        // device stopped clocking mid-frame: drop it and resynchronise on the next start bit
        frame_error_q <= 1'b1;
        state         <= IDLE;
        idx           <= '0;
      end
    end
  end

  assign bus.byte_data    = byte_data_q;
  assign bus.byte_valid   = byte_valid_q;
  assign bus.packet_data  = packet_data_q;
  assign bus.packet_valid = packet_valid_q;
  assign bus.parity_error = parity_error_q;
  assign bus.frame_error  = frame_error_q;
  assign bus.align_error  = align_error_q;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_ps2_packet_rx.sv
// Directed bench for ps2_packet_rx: PS/2 frames driven bit by bit, expected events queued.
// Latency: results compared when the DUT pulses, each against the head of the queue.
// Backpressure: none; the bench waits on the queue draining within a cycle budget.
module tb_ps2_packet_rx;

  logic clk;
  logic reset;

  ps2_packet_rx_if #(.PACKET_BYTES(3)) bus ();

  ps2_packet_rx #(
    .SYNC_STAGES   (2),
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(1000),
    .PACKET_BYTES  (3),
    .SYNC_BIT_CHECK(1'b1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    logic        bv;
    logic        pv;
    logic        pe;
    logic        fe;
    logic        ae;
    logic [7:0]  bd;
    logic [23:0] pd;
  } ev_t;

  ev_t exp_q[$];

  int n_assert = 0;
  int n_fail   = 0;

  // reference model of what the receiver should hold
  int          m_idx  = 0;
  logic [7:0]  m_slot [3];
  logic [7:0]  m_byte = 8'h00;
  logic [23:0] m_pkt  = 24'h0;

  longint last_fall_t = 0;
  longint err_t       = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_good(input logic [7:0] b);
    ev_t e;
    e.bv = 1'b1; e.pv = 1'b0; e.pe = 1'b0; e.fe = 1'b0; e.ae = 1'b0;
    m_byte = b;
    if (m_idx == 0 && !b[3]) begin
      e.ae = 1'b1;
    end else begin
      m_slot[m_idx] = b;
      if (m_idx == 2) begin
        m_pkt = {m_slot[2], m_slot[1], m_slot[0]};
        e.pv  = 1'b1;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
    e.bd = m_byte;
    e.pd = m_pkt;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic pe, input logic fe);
    ev_t e;
    e.bv = 1'b0; e.pv = 1'b0; e.pe = pe; e.fe = fe; e.ae = 1'b0;
    m_idx = 0;
    e.bd = m_byte;
    e.pd = m_pkt;
    exp_q.push_back(e);
  endtask

  // start, 8 data LSB first, parity, stop; only the first nbits are clocked out
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop, input int nbits);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      bus.data_ps2 = bits[i];
      repeat (50) @(negedge clk);
      bus.clk_ps2 = 1'b0;
      last_fall_t = $time;
      repeat (100) @(negedge clk);
      bus.clk_ps2 = 1'b1;
      repeat (50) @(negedge clk);
    end
    if (nbits == 11) begin
      bus.data_ps2 = 1'b1;
      repeat (100) @(negedge clk);
    end
  endtask

  task automatic send_good(input logic [7:0] b);
    push_good(b);
    send_frame(b, ~^b, 1'b1, 11);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_byte_data"},    bus.byte_data, 0);
    chk({tag, "_byte_valid"},   bus.byte_valid, 0);
    chk({tag, "_packet_data"},  bus.packet_data, 0);
    chk({tag, "_packet_valid"}, bus.packet_valid, 0);
    chk({tag, "_parity_error"}, bus.parity_error, 0);
    chk({tag, "_frame_error"},  bus.frame_error, 0);
    chk({tag, "_align_error"},  bus.align_error, 0);
    chk({tag, "_busy"},         bus.busy, 0);
  endtask

  // scoreboard: every cycle with a pulse is matched against the oldest expected event
  always @(negedge clk) begin
    logic [4:0] pulses;
    ev_t e;
    pulses = {bus.byte_valid, bus.packet_valid, bus.parity_error, bus.frame_error, bus.align_error};
    if (reset && pulses != 5'b0) begin
      if (bus.frame_error) err_t = $time;
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {27'b0, pulses}, 0);
      end else begin
        e = exp_q.pop_front();
        chk("ev_byte_valid",   bus.byte_valid,   e.bv);
        chk("ev_packet_valid", bus.packet_valid, e.pv);
        chk("ev_parity_error", bus.parity_error, e.pe);
        chk("ev_frame_error",  bus.frame_error,  e.fe);
        chk("ev_align_error",  bus.align_error,  e.ae);
        chk("ev_byte_data",    bus.byte_data,    e.bd);
        chk("ev_packet_data",  bus.packet_data,  e.pd);
      end
    end
  end

  initial begin
    longint lat;
    logic   busy_seen;

    reset        = 1'b0;
    bus.clk_ps2  = 1'b1;
    bus.data_ps2 = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b1;
    repeat (20) @(negedge clk);

    // three good bytes make one packet
    send_good(8'h08);
    send_good(8'h05);
    send_good(8'hFB);
    drain("t1_drain");
    chk("t1_packet", bus.packet_data, 24'hFB0508);

    // bad parity drops the byte and restarts assembly
    push_err(1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b1, 11);
    send_good(8'h08);
    send_good(8'h01);
    send_good(8'h02);
    drain("t2_drain");
    chk("t2_packet", bus.packet_data, 24'h020108);

    // stop bit low: frame error, held byte unchanged
    push_err(1'b0, 1'b1);
    send_frame(8'h08, 1'b0, 1'b0, 11);
    drain("t3_drain");
    chk("t3_byte_held", bus.byte_data, 8'h02);

    // clock stops after 4 data bits: timeout frame error
    push_err(1'b0, 1'b1);
    send_frame(8'h08, 1'b0, 1'b1, 5);
    drain("t4_drain");
    lat = (err_t - last_fall_t) / 10;
    chk("t4_timeout_window", (lat >= 1000 && lat <= 1020) ? 32'd1 : 32'd0, 1);
    chk("t4_busy", bus.busy, 0);
    send_good(8'h08);
    drain("t4_recover");
    chk("t4_byte", bus.byte_data, 8'h08);

    // bad stop frame to bring the packet index back to zero
    push_err(1'b0, 1'b1);
    send_frame(8'h55, ~^8'h55, 1'b0, 11);
    drain("t5_clear");

    // misaligned first byte is reported and not stored
    send_good(8'h00);
    send_good(8'h08);
    send_good(8'h01);
    send_good(8'h02);
    drain("t5_drain");
    chk("t5_packet", bus.packet_data, 24'h020108);

    // short low glitch on the PS/2 clock must not start a frame
    bus.clk_ps2 = 1'b0;
    repeat (2) @(negedge clk);
    bus.clk_ps2 = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      busy_seen = busy_seen | bus.busy;
    end
    chk("t6_glitch_busy", busy_seen, 0);

    // reset in the middle of a frame
    send_frame(8'h08, 1'b0, 1'b1, 4);
    repeat (10) @(negedge clk);
    chk("t6_busy_midframe", bus.busy, 1);
    #3;
    reset = 1'b0;
    #1;
    chk_all_zero("t6_reset");
    m_idx  = 0;
    m_byte = 8'h00;
    m_pkt  = 24'h0;
    bus.clk_ps2  = 1'b1;
    bus.data_ps2 = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    send_good(8'h08);
    send_good(8'h01);
    send_good(8'h02);
    drain("t6_drain");
    chk("t6_packet", bus.packet_data, 24'h020108);

    repeat (20) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
